// File: rtl/scanner_pkg.sv
// Shared widths, default frame geometry and state encodings for the laser line finder.
package scanner_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SCORE_W      = 9;
    localparam int COORD_W      = 10;
    localparam int PIX_W        = 8;

    typedef enum logic {IDLE, SCAN} scan_state_t;
    typedef enum logic [1:0] {EMIT_IDLE, EMIT_HIGH, EMIT_LOW} emit_state_t;
endpackage

// File: rtl/point_pulse_gen.sv
// Point emitter: latches x/y, holds the pulse high then low for PULSE_CYCLES each, and
// flags any point that arrives while it is busy.
module point_pulse_gen
    import scanner_pkg::*;
#(
    parameter int PULSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pulse,
    output logic               drop
);
    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    emit_state_t        state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [COORD_W-1:0] x_d, x_q, y_d, y_q;
    logic               pulse_d, pulse_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        drop    = 1'b0;
        case (state_q)
            EMIT_IDLE: begin
                if (start) begin
                    state_d = EMIT_HIGH;
                    cnt_d   = '0;
                    x_d     = x_in;
                    y_d     = y_in;
                end
            end
            EMIT_HIGH, EMIT_LOW: begin
                drop = start;
                if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == EMIT_HIGH) ? EMIT_LOW : EMIT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = EMIT_IDLE;
        endcase
        // Registered pulse so the writer sees a clean flop output.
        pulse_d = (state_d == EMIT_HIGH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMIT_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pulse_q <= pulse_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign pulse = pulse_q;
endmodule

// File: rtl/laser_line_finder.sv
// Laser line finder: per-row red-minus-green peak search feeding a stretched point pulse.
// Define LASER_WIDTH_FILTER_EN to suppress rows whose above-threshold run is wider than MAX_WIDTH.
module laser_line_finder
    import scanner_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int THRESH       = 40,
    parameter int PULSE_CYCLES = 4,
    parameter int MAX_WIDTH    = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_enable,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic [PIX_W-1:0]   red,
    input  logic [PIX_W-1:0]   green,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               point_ready_pulse,
    output logic               frame_done,
    output logic [7:0]         dropped_count
);
    localparam logic [COORD_W-1:0] ROW_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] FRAME_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [SCORE_W-1:0] THRESH_S   = SCORE_W'(THRESH);

    if (PULSE_CYCLES < 1 || MAX_WIDTH < 1) begin : g_param_check
        $error("PULSE_CYCLES and MAX_WIDTH must be positive");
    end

    function automatic logic [SCORE_W-1:0] clamp_score(input logic [PIX_W-1:0] r,
                                                       input logic [PIX_W-1:0] g);
        logic signed [SCORE_W:0] diff;
        diff = $signed({2'b00, r}) - $signed({2'b00, g});
        clamp_score = diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic               vld_p1_d, vld_p1_q, scan_en_p1_d, scan_en_p1_q;
    logic [COORD_W-1:0] hcount_p1_d, hcount_p1_q, vcount_p1_d, vcount_p1_q;
    logic [PIX_W-1:0]   red_p1_d, red_p1_q, green_p1_d, green_p1_q;

    // Stage 1: input capture
    always_comb begin
        vld_p1_d     = pixel_valid;
        scan_en_p1_d = scan_enable;
        hcount_p1_d  = hcount;
        vcount_p1_d  = vcount;
        red_p1_d     = red;
        green_p1_d   = green;
    end

    scan_state_t        scan_d, scan_q;
    logic [SCORE_W-1:0] score, peak_d, peak_q;
    logic [COORD_W-1:0] peak_x_d, peak_x_q, row_y_p2_d, row_y_p2_q;
    logic               frame_start, active, row_end, clear;
    logic               row_end_p2_d, row_end_p2_q, last_row_p2_d, last_row_p2_q;

    // Stage 2: score, frame tracking and running row peak
    always_comb begin
        score       = clamp_score(red_p1_q, green_p1_q);
        frame_start = vld_p1_q && (hcount_p1_q == '0) && (vcount_p1_q == '0);
        active      = vld_p1_q && (frame_start ? scan_en_p1_q : (scan_q == SCAN));
        row_end     = active && (hcount_p1_q == ROW_LAST);
        scan_d      = scan_q;
        if (frame_start) begin
            scan_d = scan_en_p1_q ? SCAN : IDLE;
        end else if (row_end && (vcount_p1_q == FRAME_LAST)) begin
            scan_d = IDLE;
        end
        // A frame start also throws away any partial row from a short frame.
        clear    = row_end_p2_q || frame_start;
        peak_d   = clear ? '0 : peak_q;
        peak_x_d = clear ? '0 : peak_x_q;
        if (active && (score > peak_d)) begin
            peak_d   = score;
            peak_x_d = hcount_p1_q;
        end
        row_end_p2_d  = row_end;
        row_y_p2_d    = vcount_p1_q;
        last_row_p2_d = (vcount_p1_q == FRAME_LAST);
    end

    logic width_ok;
`ifdef LASER_WIDTH_FILTER_EN
    logic [COORD_W-1:0] width_d, width_q;

    always_comb begin
        width_d = clear ? '0 : width_q;
        if (active && (score >= THRESH_S) && (width_d != '1)) begin
            width_d = width_d + COORD_W'(1);
        end
        width_ok = (width_q <= COORD_W'(MAX_WIDTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_q <= '0;
        end else begin
            width_q <= width_d;
        end
    end
`else
    assign width_ok = 1'b1;
`endif

    logic       emit_start, drop, frame_done_d, frame_done_q;
    logic [7:0] dropped_d, dropped_q;

    // Stage 3: row decision, frame strobe and drop accounting
    always_comb begin
        emit_start   = row_end_p2_q && (peak_q >= THRESH_S) && width_ok;
        frame_done_d = row_end_p2_q && last_row_p2_q;
        dropped_d    = drop ? sat_inc8(dropped_q) : dropped_q;
    end

    always_ff @(posedge clk) begin
        scan_en_p1_q  <= scan_en_p1_d;
        hcount_p1_q   <= hcount_p1_d;
        vcount_p1_q   <= vcount_p1_d;
        red_p1_q      <= red_p1_d;
        green_p1_q    <= green_p1_d;
        row_y_p2_q    <= row_y_p2_d;
        last_row_p2_q <= last_row_p2_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1_q     <= 1'b0;
            scan_q       <= IDLE;
            peak_q       <= '0;
            peak_x_q     <= '0;
            row_end_p2_q <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            scan_q       <= scan_d;
            peak_q       <= peak_d;
            peak_x_q     <= peak_x_d;
            row_end_p2_q <= row_end_p2_d;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
        end
    end

    point_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_emit (
        .clk  (clk),
        .reset(reset),
        .start(emit_start),
        .x_in (peak_x_q),
        .y_in (row_y_p2_q),
        .x    (x),
        .y    (y),
        .pulse(point_ready_pulse),
        .drop (drop)
    );

    assign frame_done    = frame_done_q;
    assign dropped_count = dropped_q;
endmodule

// File: tb/tb_laser_line_finder.sv
// Directed bench for laser_line_finder: peak search, thresholds, drops, frame control, reset.
module tb_laser_line_finder;
    logic       clk = 1'b0;
    logic       reset, scan_enable, pixel_valid;
    logic [9:0] hcount, vcount, x, y;
    logic [7:0] red, green, dropped_count;
    logic       point_ready_pulse, frame_done;

    int checks = 0;
    int errors = 0;

    int   pulse_cnt = 0, fd_cnt = 0, xy_bad = 0, hi_len = 0, last_hi_len = 0;
    logic [9:0] last_x = '0, last_y = '0;
    logic pulse_prev = 1'b0;

    laser_line_finder dut (
        .clk              (clk),
        .reset            (reset),
        .scan_enable      (scan_enable),
        .pixel_valid      (pixel_valid),
        .hcount           (hcount),
        .vcount           (vcount),
        .red              (red),
        .green            (green),
        .x                (x),
        .y                (y),
        .point_ready_pulse(point_ready_pulse),
        .frame_done       (frame_done),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    // Records pulse rises, high lengths, x/y stability and frame strobes.
    always @(negedge clk) begin
        if (point_ready_pulse && !pulse_prev) begin
            pulse_cnt = pulse_cnt + 1;
            last_x    = x;
            last_y    = y;
            hi_len    = 1;
        end else if (point_ready_pulse) begin
            hi_len = hi_len + 1;
            if (x !== last_x || y !== last_y) xy_bad = xy_bad + 1;
        end else if (pulse_prev) begin
            last_hi_len = hi_len;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        pulse_prev = point_ready_pulse;
    end

    task automatic drive(input logic v, input int h, input int vc, input int r, input int g);
        @(negedge clk);
        pixel_valid = v;
        hcount      = h[9:0];
        vcount      = vc[9:0];
        red         = r[7:0];
        green       = g[7:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        reset = 1'b0; scan_enable = 1'b0;
        idle(3);
        checks++; if (x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (y !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
        checks++; if (point_ready_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", point_ready_pulse); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped_count); end
        @(negedge clk); reset = 1'b1;
        idle(2);
    endtask

    task automatic test_single_peak;
        int c0;
        logic exp_p;
        c0 = pulse_cnt;
        scan_enable = 1'b1;
        drive(1'b1, 0, 0, 0, 0);
        for (int r = 0; r < 5; r++) drive(1'b1, 639, r, 0, 0);
        drive(1'b1, 317, 5, 200, 10);
        drive(1'b1, 639, 5, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            exp_p = (k >= 3 && k <= 6);
            checks++;
            if (point_ready_pulse !== exp_p) begin
                errors++; $display("FAIL single_pulse_k%0d got %b want %b", k, point_ready_pulse, exp_p);
            end
        end
        idle(4);
        checks++; if (pulse_cnt !== c0 + 1) begin errors++; $display("FAIL single_count got %0d want %0d", pulse_cnt, c0 + 1); end
        checks++; if (last_x !== 10'd317) begin errors++; $display("FAIL single_x got %0d want 317", last_x); end
        checks++; if (last_y !== 10'd5) begin errors++; $display("FAIL single_y got %0d want 5", last_y); end
        checks++; if (last_hi_len !== 4) begin errors++; $display("FAIL single_high_len got %0d want 4", last_hi_len); end
        checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL single_dropped got %0d want 0", dropped_count); end
    endtask

    task automatic test_first_max;
        int c0;
        c0 = pulse_cnt;
        drive(1'b1, 639, 6, 0, 0);
        drive(1'b1, 50, 7, 100, 0);
        drive(1'b1, 400, 7, 150, 50);
        drive(1'b1, 639, 7, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 1) begin errors++; $display("FAIL firstmax_count got %0d want %0d", pulse_cnt, c0 + 1); end
        checks++; if (last_x !== 10'd50) begin errors++; $display("FAIL firstmax_x got %0d want 50", last_x); end
        checks++; if (last_y !== 10'd7) begin errors++; $display("FAIL firstmax_y got %0d want 7", last_y); end
    endtask

    task automatic test_below_thresh;
        int c0;
        c0 = pulse_cnt;
        drive(1'b1, 100, 8, 39, 0);
        drive(1'b0, 300, 8, 255, 0);
        drive(1'b1, 639, 8, 0, 0);
        drive(1'b1, 200, 9, 10, 200);
        drive(1'b1, 639, 9, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0) begin errors++; $display("FAIL thresh_no_pulse got %0d want %0d", pulse_cnt, c0); end
        drive(1'b1, 20, 10, 90, 0);
        drive(1'b0, 639, 10, 0, 0);
        drive(1'b1, 30, 10, 95, 5);
        drive(1'b1, 639, 10, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 1) begin errors++; $display("FAIL invalid_rowend_count got %0d want %0d", pulse_cnt, c0 + 1); end
        checks++; if (last_x !== 10'd20) begin errors++; $display("FAIL tie_x got %0d want 20", last_x); end
        checks++; if (last_y !== 10'd10) begin errors++; $display("FAIL tie_y got %0d want 10", last_y); end
        checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL thresh_dropped got %0d want 0", dropped_count); end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = pulse_cnt;
        drive(1'b1, 100, 11, 200, 0);
        drive(1'b1, 639, 11, 0, 0);
        idle(2);
        drive(1'b1, 100, 12, 150, 0);
        drive(1'b1, 639, 12, 0, 0);
        idle(12);
        checks++; if (dropped_count !== 8'd1) begin errors++; $display("FAIL b2b_dropped got %0d want 1", dropped_count); end
        checks++; if (pulse_cnt !== c0 + 1) begin errors++; $display("FAIL b2b_count got %0d want %0d", pulse_cnt, c0 + 1); end
        checks++; if (last_y !== 10'd11) begin errors++; $display("FAIL b2b_y got %0d want 11", last_y); end
        checks++; if (xy_bad !== 0) begin errors++; $display("FAIL xy_stable got %0d want 0", xy_bad); end
    endtask

    task automatic test_low_phase;
        int c0;
        c0 = pulse_cnt;
        drive(1'b1, 10, 13, 200, 0);
        drive(1'b1, 639, 13, 0, 0);
        idle(5);
        drive(1'b1, 20, 14, 200, 0);
        drive(1'b1, 639, 14, 0, 0);
        idle(14);
        checks++; if (dropped_count !== 8'd2) begin errors++; $display("FAIL low_drop got %0d want 2", dropped_count); end
        drive(1'b1, 10, 15, 200, 0);
        drive(1'b1, 639, 15, 0, 0);
        idle(7);
        drive(1'b1, 20, 16, 200, 0);
        drive(1'b1, 639, 16, 0, 0);
        idle(14);
        checks++; if (dropped_count !== 8'd2) begin errors++; $display("FAIL after_low_dropped got %0d want 2", dropped_count); end
        checks++; if (pulse_cnt !== c0 + 3) begin errors++; $display("FAIL after_low_count got %0d want %0d", pulse_cnt, c0 + 3); end
        checks++; if (last_x !== 10'd20 || last_y !== 10'd16) begin
            errors++; $display("FAIL after_low_xy got %0d,%0d want 20,16", last_x, last_y);
        end
    endtask

    task automatic test_saturate_and_frame_done;
        logic exp_fd;
        for (int i = 0; i < 400; i++) drive(1'b1, 639, 17, 200, 0);
        idle(14);
        checks++; if (dropped_count !== 8'd255) begin errors++; $display("FAIL sat_dropped got %0d want 255", dropped_count); end
        for (int i = 0; i < 20; i++) drive(1'b1, 639, 17, 200, 0);
        idle(14);
        checks++; if (dropped_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", dropped_count); end
        checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL fd_early got %0d want 0", fd_cnt); end
        drive(1'b1, 639, 479, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            exp_fd = (k == 3);
            checks++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL frame_done_k%0d got %b want %b", k, frame_done, exp_fd);
            end
        end
        idle(4);
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL fd_count got %0d want 1", fd_cnt); end
    endtask

    task automatic test_scan_enable;
        int c0;
        c0 = pulse_cnt;
        scan_enable = 1'b0;
        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 100, 1, 200, 0);
        drive(1'b1, 639, 1, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0) begin errors++; $display("FAIL disabled_no_pulse got %0d want %0d", pulse_cnt, c0); end
        scan_enable = 1'b1;
        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 50, 0, 200, 0);
        drive(1'b1, 639, 0, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 1 || last_x !== 10'd50 || last_y !== 10'd0) begin
            errors++; $display("FAIL enabled_point got cnt %0d xy %0d,%0d want cnt %0d xy 50,0", pulse_cnt, last_x, last_y, c0 + 1);
        end
        scan_enable = 1'b0;
        drive(1'b1, 70, 1, 200, 0);
        drive(1'b1, 639, 1, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 2 || last_x !== 10'd70) begin
            errors++; $display("FAIL midframe_enable got cnt %0d x %0d want cnt %0d x 70", pulse_cnt, last_x, c0 + 2);
        end
        scan_enable = 1'b1;
        drive(1'b1, 60, 2, 200, 0);
        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 639, 0, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 2) begin errors++; $display("FAIL short_frame_discard got %0d want %0d", pulse_cnt, c0 + 2); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL short_frame_fd got %0d want 1", fd_cnt); end
    endtask

    task automatic test_reset_mid_emit;
        int c0;
        drive(1'b1, 100, 3, 200, 0);
        drive(1'b1, 639, 3, 0, 0);
        idle(4);
        checks++; if (point_ready_pulse !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse got %b want 1", point_ready_pulse); end
        #2 reset = 1'b0;
        #1;
        checks++; if (point_ready_pulse !== 1'b0 || x !== 10'd0 || y !== 10'd0) begin
            errors++; $display("FAIL async_reset_out got p%b x%0d y%0d want p0 x0 y0", point_ready_pulse, x, y);
        end
        checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL async_reset_dropped got %0d want 0", dropped_count); end
        idle(2);
        @(negedge clk); reset = 1'b1;
        c0 = pulse_cnt;
        drive(1'b1, 100, 4, 200, 0);
        drive(1'b1, 639, 4, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0) begin errors++; $display("FAIL post_reset_idle got %0d want %0d", pulse_cnt, c0); end
        scan_enable = 1'b1;
        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 80, 0, 200, 0);
        drive(1'b1, 639, 0, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 1 || last_x !== 10'd80 || last_y !== 10'd0) begin
            errors++; $display("FAIL post_reset_frame got cnt %0d xy %0d,%0d want cnt %0d xy 80,0", pulse_cnt, last_x, last_y, c0 + 1);
        end
    endtask

`ifdef LASER_WIDTH_FILTER_EN
    task automatic test_width_filter;
        int c0;
        c0 = pulse_cnt;
        scan_enable = 1'b1;
        drive(1'b1, 0, 0, 0, 0);
        drive(1'b1, 639, 0, 0, 0);
        for (int i = 0; i < 30; i++) drive(1'b1, 100 + i, 1, 120, 0);
        drive(1'b1, 639, 1, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0) begin errors++; $display("FAIL wide_suppressed got %0d want %0d", pulse_cnt, c0); end
        checks++; if (dropped_count !== 8'd0) begin errors++; $display("FAIL wide_dropped got %0d want 0", dropped_count); end
        for (int i = 0; i < 20; i++) drive(1'b1, 200 + i, 2, 120, 0);
        drive(1'b1, 639, 2, 0, 0);
        idle(12);
        checks++; if (pulse_cnt !== c0 + 1 || last_x !== 10'd200 || last_y !== 10'd2) begin
            errors++; $display("FAIL narrow_point got cnt %0d xy %0d,%0d want cnt %0d xy 200,2", pulse_cnt, last_x, last_y, c0 + 1);
        end
    endtask
`endif

    initial begin
        pixel_valid = 1'b0; hcount = '0; vcount = '0; red = '0; green = '0;
        reset = 1'b0; scan_enable = 1'b0;
        test_reset();
        test_single_peak();
        test_first_max();
        test_below_thresh();
        test_back_to_back();
        test_low_phase();
        test_saturate_and_frame_done();
        test_scan_enable();
        test_reset_mid_emit();
`ifdef LASER_WIDTH_FILTER_EN
        test_width_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
